cdiff_trace_buf: RTL and testbench

//  Multi-channel L1 cache-write trace collector; successor to the single-pipe CDIFF printer.
//  - Per channel: aligns tag/state/data write enables from their native mempipe stages to one

---
 rtl/cdiff_trace_buf_pkg.sv | 44 ++++
 rtl/cdiff_delay_line.sv | 31 +++
 rtl/cdiff_trace_buf.sv | 150 +++++++++++++++
 tb/tb_cdiff_trace_buf.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cdiff_trace_buf_pkg.sv
// rtl/cdiff_trace_buf_pkg.sv - shared cache-trace types: set/way/arb, event kind and record
package cdiff_trace_buf_pkg;

  localparam int L1_SET_W     = 6;
  localparam int L1_WAY_W     = 2;
  localparam int CDIFF_TS_W   = 32;
  localparam int CDIFF_CH_W   = 2;   // channel index field; covers up to 4 mempipes
  localparam int CDIFF_DROP_W = 16;

  typedef logic [L1_SET_W-1:0] t_l1_set_addr;
  typedef logic [L1_WAY_W-1:0] t_l1_way;

  typedef enum logic [1:0] {
    ARB_MISS  = 2'd0,
    ARB_FILL  = 2'd1,
    ARB_EVICT = 2'd2,
    ARB_SNOOP = 2'd3
  } t_mempipe_arb_type;

  typedef struct packed {
    logic tag;
    logic state;
    logic data;
  } t_cdiff_kind;

  typedef struct packed {
    logic [CDIFF_TS_W-1:0] ts;
    logic [CDIFF_CH_W-1:0] ch;
    t_l1_set_addr          set;
    t_l1_way               way;
    t_mempipe_arb_type     arb;
    t_cdiff_kind           kind;
  } t_cdiff_evt;

  function automatic t_cdiff_kind cdiff_mk_kind(input logic tag, input logic state,
                                                input logic data);
    t_cdiff_kind k;
    k.tag   = tag;
    k.state = state;
    k.data  = data;
    return k;
  endfunction

endpackage

// File: rtl/cdiff_delay_line.sv
// rtl/cdiff_delay_line.sv - clean 1-bit shift register; DLY=0 degenerates to a wire
module cdiff_delay_line #(
  parameter int DLY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  generate
    if (DLY == 0) begin : g_wire
      assign o_q = i_d;
    end else if (DLY == 1) begin : g_one
      logic r_q;
      always_ff @(posedge clk) begin
        if (!reset) r_q <= 1'b0;
        else        r_q <= i_d;
      end
      assign o_q = r_q;
    end else begin : g_shift
      logic [DLY-1:0] r_sh;
      always_ff @(posedge clk) begin
        if (!reset) r_sh <= '0;
        else        r_sh <= {r_sh[DLY-2:0], i_d};
      end
      assign o_q = r_sh[DLY-1];
    end
  endgenerate

endmodule

// File: rtl/cdiff_trace_buf.sv
// rtl/cdiff_trace_buf.sv - multi-channel L1 write trace collector with filtered event FIFO
`ifndef SYNTHESIS
`ifndef PMSG
`define PMSG(tag, msg) $display("[%s] %s", tag, msg)
`endif
`endif

module cdiff_trace_buf
  import cdiff_trace_buf_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DEPTH     = 16,
  parameter int TAG_DLY   = 3,
  parameter int STATE_DLY = 1,
  parameter int DATA_DLY  = 1,
  parameter int TS_W      = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CH-1:0]                    i_ch_tag_wr_en,
  input  logic [NUM_CH-1:0]                    i_ch_state_wr_en,
  input  logic [NUM_CH-1:0]                    i_ch_data_wr_en,
  input  t_l1_set_addr      [NUM_CH-1:0]       i_ch_set_cmt,
  input  t_l1_way           [NUM_CH-1:0]       i_ch_way_cmt,
  input  t_mempipe_arb_type [NUM_CH-1:0]       i_ch_arb_cmt,
  input  logic                                 i_filt_en,
  input  t_l1_set_addr                         i_filt_set,
  output logic                                 o_out_valid,
  input  logic                                 i_out_ready,
  output t_cdiff_evt                           o_out_evt,
  output logic [$clog2(DEPTH):0]               o_occupancy,
  output logic [CDIFF_DROP_W-1:0]              o_drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = AW + 1;
  localparam int NC_W  = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0] w_tag_d;
  logic [NUM_CH-1:0] w_state_d;
  logic [NUM_CH-1:0] w_data_d;

  genvar gc;
  generate
    for (gc = 0; gc < NUM_CH; gc++) begin : g_ch
      cdiff_delay_line #(.DLY(TAG_DLY)) u_tag (
        .clk(clk), .reset(reset), .i_d(i_ch_tag_wr_en[gc]), .o_q(w_tag_d[gc]));
      cdiff_delay_line #(.DLY(STATE_DLY)) u_state (
        .clk(clk), .reset(reset), .i_d(i_ch_state_wr_en[gc]), .o_q(w_state_d[gc]));
      cdiff_delay_line #(.DLY(DATA_DLY)) u_data (
        .clk(clk), .reset(reset), .i_d(i_ch_data_wr_en[gc]), .o_q(w_data_d[gc]));
    end
  endgenerate

  logic [TS_W-1:0]     r_ts;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [OCC_W-1:0]    r_occ;
  logic [CDIFF_DROP_W-1:0] r_drop;
  t_cdiff_evt          r_mem [DEPTH];

  t_cdiff_evt          w_evt [NUM_CH];
  logic [NUM_CH-1:0]   w_keep;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_evt[c]      = '0;
      w_evt[c].ts   = CDIFF_TS_W'(r_ts);
      w_evt[c].ch   = CDIFF_CH_W'(c);
      w_evt[c].set  = i_ch_set_cmt[c];
      w_evt[c].way  = i_ch_way_cmt[c];
      w_evt[c].arb  = i_ch_arb_cmt[c];
      w_evt[c].kind = cdiff_mk_kind(w_tag_d[c], w_state_d[c], w_data_d[c]);
      w_keep[c]     = (w_evt[c].kind != '0) &&
                      (!i_filt_en || (i_ch_set_cmt[c] == i_filt_set));
    end
  end

  // Free space is fixed at cycle start; a pop in the same cycle never frees a slot.
  logic [OCC_W-1:0]  w_free;
  logic [OCC_W-1:0]  w_n_enq;
  logic [NC_W-1:0]   w_n_drop;
  logic [NUM_CH-1:0] w_wr_en;
  logic [AW-1:0]     w_wr_idx [NUM_CH];

  always_comb begin
    w_free   = OCC_W'(DEPTH) - r_occ;
    w_n_enq  = '0;
    w_n_drop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_wr_en[c]  = 1'b0;
      w_wr_idx[c] = r_wr_ptr + w_n_enq[AW-1:0];
      if (w_keep[c]) begin
        if (w_n_enq < w_free) begin
          w_wr_en[c] = 1'b1;
          w_n_enq    = w_n_enq + OCC_W'(1);
        end else begin
          w_n_drop = w_n_drop + NC_W'(1);
        end
      end
    end
  end

  logic                  w_pop;
  logic [CDIFF_DROP_W:0] w_drop_sum;

  assign w_pop      = (r_occ != '0) && i_out_ready;
  assign w_drop_sum = {1'b0, r_drop} + (CDIFF_DROP_W + 1)'(w_n_drop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ts     <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_drop   <= '0;
    end else begin
      r_ts     <= r_ts + TS_W'(1);
      r_wr_ptr <= r_wr_ptr + w_n_enq[AW-1:0];
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_occ    <= r_occ + w_n_enq - OCC_W'(w_pop);
      r_drop   <= w_drop_sum[CDIFF_DROP_W] ? '1 : w_drop_sum[CDIFF_DROP_W-1:0];
    end
  end

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_wr_en[c]) r_mem[w_wr_idx[c]] <= w_evt[c];
    end
  end

  assign o_out_valid = (r_occ != '0);
  assign o_out_evt   = r_mem[r_rd_ptr];
  assign o_occupancy = r_occ;
  assign o_drop_cnt  = r_drop;

`ifndef SYNTHESIS
  localparam string CDIFF = "CDIFF";

  always_ff @(posedge clk) begin
    if (reset && w_pop) begin
      `PMSG(CDIFF, $sformatf("ch=%0d set=%0d way=%0d kind=%03b arb=%0d ts=%0d",
                             o_out_evt.ch, o_out_evt.set, o_out_evt.way,
                             o_out_evt.kind, o_out_evt.arb, o_out_evt.ts));
    end
  end
`endif

endmodule

// File: tb/tb_cdiff_trace_buf.sv
// tb/tb_cdiff_trace_buf.sv - bench for cdiff_trace_buf against a queue-based event model
module tb_cdiff_trace_buf;
  import cdiff_trace_buf_pkg::*;

  localparam int NUM_CH    = 2;
  localparam int DEPTH     = 16;
  localparam int TAG_DLY   = 3;
  localparam int STATE_DLY = 1;
  localparam int DATA_DLY  = 1;
  localparam int OCC_W     = $clog2(DEPTH) + 1;

  logic                           clk;
  logic                           reset;
  logic [NUM_CH-1:0]              tag_en, st_en, dt_en;
  t_l1_set_addr      [NUM_CH-1:0] ch_set;
  t_l1_way           [NUM_CH-1:0] ch_way;
  t_mempipe_arb_type [NUM_CH-1:0] ch_arb;
  logic                           filt_en;
  t_l1_set_addr                   filt_set;
  logic                           out_valid;
  logic                           out_ready;
  t_cdiff_evt                     out_evt;
  logic [OCC_W-1:0]               occupancy;
  logic [CDIFF_DROP_W-1:0]        drop_cnt;

  cdiff_trace_buf #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .TAG_DLY(TAG_DLY),
    .STATE_DLY(STATE_DLY), .DATA_DLY(DATA_DLY), .TS_W(32)
  ) dut (
    .clk(clk), .reset(reset),
    .i_ch_tag_wr_en(tag_en), .i_ch_state_wr_en(st_en), .i_ch_data_wr_en(dt_en),
    .i_ch_set_cmt(ch_set), .i_ch_way_cmt(ch_way), .i_ch_arb_cmt(ch_arb),
    .i_filt_en(filt_en), .i_filt_set(filt_set),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_evt(out_evt),
    .o_occupancy(occupancy), .o_drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: scheduled enables per commit cycle, the buffered events, and the drop total.
  int                cyc;
  int                set_ovr;
  bit [NUM_CH-1:0]   p_tag [64];
  bit [NUM_CH-1:0]   p_st  [64];
  bit [NUM_CH-1:0]   p_dt  [64];
  t_cdiff_evt        mq [$];
  int                m_drop;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (mq.size() != 0) chk("out_evt", 64'(out_evt), 64'(mq[0]));
  endtask

  task automatic model_clear();
    mq.delete();
    m_drop = 0;
    for (int i = 0; i < 64; i++) begin
      p_tag[i] = '0;
      p_st[i]  = '0;
      p_dt[i]  = '0;
    end
  endtask

  task automatic do_reset();
    tag_en = '0; st_en = '0; dt_en = '0; out_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    cyc   = 0;
    reset = 1'b1;
  endtask

  // Called on a falling edge: drive this cycle, check state, advance model by one commit.
  task automatic tick(input logic [NUM_CH-1:0] tg, input logic [NUM_CH-1:0] st,
                      input logic [NUM_CH-1:0] dt, input logic rdy);
    int k, free, n;
    bit pop;
    t_cdiff_kind kd;
    t_cdiff_evt  e;
    tag_en = tg; st_en = st; dt_en = dt; out_ready = rdy;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_set[c] = t_l1_set_addr'((cyc * 3 + c * 7) % 64);
      ch_way[c] = t_l1_way'((cyc + c) % 4);
      ch_arb[c] = t_mempipe_arb_type'((cyc + 2 * c) % 4);
    end
    if (set_ovr >= 0) ch_set[0] = t_l1_set_addr'(set_ovr);
    check_outputs();
    p_tag[(cyc + TAG_DLY) % 64]   |= tg;
    p_st[(cyc + STATE_DLY) % 64]  |= st;
    p_dt[(cyc + DATA_DLY) % 64]   |= dt;
    k    = cyc % 64;
    free = DEPTH - mq.size();
    pop  = (mq.size() != 0) && rdy;
    n    = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      kd = '{tag: p_tag[k][c], state: p_st[k][c], data: p_dt[k][c]};
      if (kd != '0 && (!filt_en || ch_set[c] == filt_set)) begin
        if (n < free) begin
          e = '{ts: 32'(cyc), ch: CDIFF_CH_W'(c), set: ch_set[c], way: ch_way[c],
                arb: ch_arb[c], kind: kd};
          mq.push_back(e);
          n++;
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
    end
    if (pop) void'(mq.pop_front());
    p_tag[k] = '0; p_st[k] = '0; p_dt[k] = '0;
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    reset = 1'b0; filt_en = 1'b0; filt_set = '0; set_ovr = -1;
    tag_en = '0; st_en = '0; dt_en = '0; out_ready = 1'b0;
    ch_set = '0; ch_way = '0; ch_arb = {NUM_CH{ARB_MISS}};
    cyc = 0;
    model_clear();
    @(negedge clk);
    do_reset();
    chk("reset_occ", 64'(occupancy), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_drop", 64'(drop_cnt), 64'd0);

    // Single tag write at cycle 10 lands at cycle 13.
    for (int i = 0; i < 16; i++) begin
      tick({1'b0, cyc == 10}, '0, '0, 1'b0);
      if (cyc == 13) chk("t1_not_yet", 64'(out_valid), 64'd0);
      if (cyc == 14) begin
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_kind", 64'(out_evt.kind), 64'b100);
        chk("t1_ts", 64'(out_evt.ts), 64'd13);
        chk("t1_ch", 64'(out_evt.ch), 64'd0);
      end
    end

    // Tag at 10, state+data at 12 merge into one record.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick({1'b0, cyc == 10}, {1'b0, cyc == 12}, {1'b0, cyc == 12}, 1'b0);
      if (cyc == 14) begin
        chk("t2_occ", 64'(occupancy), 64'd1);
        chk("t2_kind", 64'(out_evt.kind), 64'b111);
        chk("t2_ts", 64'(out_evt.ts), 64'd13);
      end
    end

    // Fill, overflow, then full with a pop and two arrivals.
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      tick((i < 10) ? 2'b00 : 2'b00, (i < 10) ? 2'b11 : 2'b00, '0, i == 10);
      if (i == 8) chk("t3_full_occ", 64'(occupancy), 64'd16);
      if (i == 9) begin
        chk("t3_drop2", 64'(drop_cnt), 64'd2);
        chk("t3_occ16", 64'(occupancy), 64'd16);
        chk("t3_head_ts", 64'(out_evt.ts), 64'd1);
      end
      if (i == 10) begin
        chk("t4_occ15", 64'(occupancy), 64'd15);
        chk("t4_drop4", 64'(drop_cnt), 64'd4);
      end
    end
    for (int i = 0; i < 18; i++) tick('0, '0, '0, 1'b1);
    chk("t4_drained", 64'(occupancy), 64'd0);

    // Filter keeps only set 5.
    do_reset();
    filt_en = 1'b1; filt_set = t_l1_set_addr'(5);
    for (int i = 0; i < 6; i++) begin
      set_ovr = (i >= 1 && i <= 3) ? 3 + i : -1;
      tick('0, (i < 3) ? 2'b01 : 2'b00, '0, 1'b0);
    end
    set_ovr = -1;
    chk("t5_occ", 64'(occupancy), 64'd1);
    chk("t5_set", 64'(out_evt.set), 64'd5);
    chk("t5_drop", 64'(drop_cnt), 64'd0);
    filt_en = 1'b0;

    // Reset with 6 queued entries and tag writes in flight.
    do_reset();
    for (int i = 0; i < 4; i++) tick((i == 3) ? 2'b11 : 2'b00, (i < 3) ? 2'b11 : 2'b00, '0, 1'b0);
    chk("t6_pre_occ", 64'(occupancy), 64'd6);
    do_reset();
    chk("t6_occ0", 64'(occupancy), 64'd0);
    chk("t6_valid0", 64'(out_valid), 64'd0);
    for (int i = 0; i < 10; i++) tick('0, '0, '0, 1'b1);
    chk("t6_no_stale", 64'(out_valid), 64'd0);

    // Sustained overflow saturates the drop counter.
    do_reset();
    for (int i = 0; i < 32780; i++) tick(2'b11, '0, '0, 1'b0);
    chk("t7_sat", 64'(drop_cnt), 64'hFFFF);
    chk("t7_occ", 64'(occupancy), 64'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
